// File: rtl/avl_arbiter_pkg.sv
// Shared types, window constants and helpers for the two-port Avalon arbiter.
package avl_arbiter_pkg;

   // Default Avalon window; the top bound is exclusive.
   localparam logic [31:0] AvlBaseAddrDefault = 32'h8000_0000;
   localparam logic [31:0] AvlTopAddrDefault  = 32'h9000_0000;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RDWAIT,
      DONE
   } avl_arb_state_t;

   typedef enum logic {
      IMEM,
      DMEM
   } avl_port_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
   } avl_req_t;

   // True when addr falls inside [base, top).
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
      return (addr >= base) && (addr < top);
   endfunction

endpackage

// File: rtl/avl_arb_hold.sv
// One-entry request holding register with a full flag, one per arbiter port.
module avl_arb_hold
   import avl_arbiter_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     valid,
   input  avl_req_t req,
   input  logic     grant,
   output logic     full,
   output avl_req_t held
);

   logic     full_q, full_d;
   avl_req_t held_q, held_d;

   // A grant with an empty register means the live request was bypassed straight
   // through, so it must not also be captured.
   always_comb begin
      full_d = full_q;
      held_d = held_q;
      if (valid && !(grant && !full_q)) begin
         full_d = 1'b1;
         held_d = req;
      end else if (grant) begin
         full_d = 1'b0;
      end
   end

   // Holding register state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full_q <= 1'b0;
         held_q <= '0;
      end else begin
         full_q <= full_d;
         held_q <= held_d;
      end
   end

   assign full = full_q;
   assign held = held_q;

endmodule

// File: rtl/avl_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between fetch and load/store.
module avl_arbiter
   import avl_arbiter_pkg::*;
#(
   parameter logic [31:0] avl_base_addr = AvlBaseAddrDefault,
   parameter logic [31:0] avl_top_addr  = AvlTopAddrDefault
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic [31:0] avl_address,
   output logic [3:0]  avl_byteenable,
   output logic        avl_read,
   output logic        avl_write,
   output logic [31:0] avl_writedata,
   input  logic [31:0] avl_readdata,
   input  logic        avl_waitrequest,
   input  logic        avl_readdatavalid
);

   avl_req_t       imem_in, dmem_in, imem_held, dmem_held, grant_req;
   logic           imem_full, dmem_full, imem_cand, dmem_cand;
   logic           imem_grant, dmem_grant, grant_valid, grant_wr;
   avl_port_t      grant_port;

   avl_arb_state_t state_q, state_d;
   avl_port_t      port_q, port_d, last_q, last_d;
   logic           wr_q, wr_d;
   logic [31:0]    address_q, address_d, wdata_q, wdata_d;
   logic [3:0]     be_q, be_d;
   logic           read_q, read_d, write_q, write_d;
   logic           imem_ready_q, imem_ready_d, dmem_ready_q, dmem_ready_d;
   logic [31:0]    imem_rdata_q, imem_rdata_d, dmem_rdata_q, dmem_rdata_d;
   logic           done_pulse;
   logic [31:0]    done_data;

   // Fetches never write; the instr bit tags the originating port.
   assign imem_in = '{addr: imem_addr, wdata: 32'h0, wstrb: 4'h0, instr: 1'b1};
   assign dmem_in = '{addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb, instr: 1'b0};

   assign imem_cand = imem_full || imem_valid;
   assign dmem_cand = dmem_full || dmem_valid;

   avl_arb_hold u_imem_hold (
      .clock (clock),
      .reset (reset),
      .valid (imem_valid),
      .req   (imem_in),
      .grant (imem_grant),
      .full  (imem_full),
      .held  (imem_held)
   );

   avl_arb_hold u_dmem_hold (
      .clock (clock),
      .reset (reset),
      .valid (dmem_valid),
      .req   (dmem_in),
      .grant (dmem_grant),
      .full  (dmem_full),
      .held  (dmem_held)
   );

   // Round-robin pick in IDLE; the held entry takes precedence over the live input.
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = IMEM;
      if (state_q == IDLE) begin
         if (imem_cand && dmem_cand) begin
            grant_port = (last_q == IMEM) ? DMEM : IMEM;
         end else if (dmem_cand) begin
            grant_port = DMEM;
         end
         grant_valid = imem_cand || dmem_cand;
      end
      if (grant_port == IMEM) begin
         grant_req = imem_full ? imem_held : imem_in;
      end else begin
         grant_req = dmem_full ? dmem_held : dmem_in;
      end
   end

   assign grant_wr   = (grant_req.wstrb != 4'h0);
   assign imem_grant = grant_valid && (grant_port == IMEM);
   assign dmem_grant = grant_valid && (grant_port == DMEM);

   // Transaction FSM next state and registered outputs.
   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      last_d       = last_q;
      wr_d         = wr_q;
      address_d    = address_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      read_d       = read_q;
      write_d      = write_q;
      imem_ready_d = 1'b0;
      dmem_ready_d = 1'b0;
      imem_rdata_d = 32'h0;
      dmem_rdata_d = 32'h0;
      done_pulse   = 1'b0;
      done_data    = 32'h0;

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               last_d = grant_port;
               port_d = grant_req.instr ? IMEM : DMEM;
               wr_d   = grant_wr;
               if (in_window(grant_req.addr, avl_base_addr, avl_top_addr)) begin
                  state_d   = CMD;
                  address_d = grant_req.addr - avl_base_addr;
                  be_d      = grant_wr ? grant_req.wstrb : 4'hF;
                  wdata_d   = grant_wr ? grant_req.wdata : 32'h0;
                  read_d    = !grant_wr;
                  write_d   = grant_wr;
               end else begin
                  // Out-of-window: no bus cycle, answer with zero data.
                  state_d = DONE;
               end
            end
         end
         CMD: begin
            if (!avl_waitrequest) begin
               read_d    = 1'b0;
               write_d   = 1'b0;
               address_d = 32'h0;
               be_d      = 4'h0;
               wdata_d   = 32'h0;
               if (wr_q) begin
                  state_d    = DONE;
                  done_pulse = 1'b1;
               end else if (avl_readdatavalid) begin
                  // Zero-latency slave returns data in the accepting cycle.
                  state_d    = DONE;
                  done_pulse = 1'b1;
                  done_data  = avl_readdata;
               end else begin
                  state_d = RDWAIT;
               end
            end
         end
         RDWAIT: begin
            if (avl_readdatavalid) begin
               state_d    = DONE;
               done_pulse = 1'b1;
               done_data  = avl_readdata;
            end
         end
         DONE: begin
            // Bus paths enter DONE with ready already raised; out-of-window entries
            // raise it here, one cycle later.
            if (imem_ready_q || dmem_ready_q) begin
               state_d = IDLE;
            end else begin
               done_pulse = 1'b1;
            end
         end
      endcase

      if (done_pulse) begin
         if (port_q == IMEM) begin
            imem_ready_d = 1'b1;
            imem_rdata_d = done_data;
         end else begin
            dmem_ready_d = 1'b1;
            dmem_rdata_d = done_data;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         port_q       <= IMEM;
         last_q       <= DMEM;
         wr_q         <= 1'b0;
         address_q    <= 32'h0;
         be_q         <= 4'h0;
         wdata_q      <= 32'h0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         imem_ready_q <= 1'b0;
         dmem_ready_q <= 1'b0;
         imem_rdata_q <= 32'h0;
         dmem_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         port_q       <= port_d;
         last_q       <= last_d;
         wr_q         <= wr_d;
         address_q    <= address_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         read_q       <= read_d;
         write_q      <= write_d;
         imem_ready_q <= imem_ready_d;
         dmem_ready_q <= dmem_ready_d;
         imem_rdata_q <= imem_rdata_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   assign avl_address    = address_q;
   assign avl_byteenable = be_q;
   assign avl_writedata  = wdata_q;
   assign avl_read       = read_q;
   assign avl_write      = write_q;
   assign imem_ready     = imem_ready_q;
   assign dmem_ready     = dmem_ready_q;
   assign imem_rdata     = imem_rdata_q;
   assign dmem_rdata     = dmem_rdata_q;

endmodule

// File: tb/tb_avl_arbiter.sv
// Bench for avl_arbiter: table of single transactions plus hand-written sequences.
module tb_avl_arbiter;

   localparam logic [31:0] Base = 32'h8000_0000;
   localparam logic [31:0] Top  = 32'h9000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_valid, dmem_valid;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] imem_rdata, dmem_rdata;
   logic        imem_ready, dmem_ready;
   logic [31:0] avl_address, avl_writedata, avl_readdata;
   logic [3:0]  avl_byteenable;
   logic        avl_read, avl_write, avl_waitrequest, avl_readdatavalid;

   avl_arbiter dut (
      .clock             (clock),
      .reset             (reset),
      .imem_valid        (imem_valid),
      .imem_addr         (imem_addr),
      .imem_rdata        (imem_rdata),
      .imem_ready        (imem_ready),
      .dmem_valid        (dmem_valid),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_wstrb        (dmem_wstrb),
      .dmem_rdata        (dmem_rdata),
      .dmem_ready        (dmem_ready),
      .avl_address       (avl_address),
      .avl_byteenable    (avl_byteenable),
      .avl_read          (avl_read),
      .avl_write         (avl_write),
      .avl_writedata     (avl_writedata),
      .avl_readdata      (avl_readdata),
      .avl_waitrequest   (avl_waitrequest),
      .avl_readdatavalid (avl_readdatavalid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Scoreboards: expected responses per port and expected bus commands in order.
   typedef struct {
      logic [31:0] rdata;
      int          due;
   } rsp_t;
   typedef struct {
      logic [31:0] address;
      logic [3:0]  be;
      logic        wr;
      logic [31:0] wdata;
   } cmd_t;

   rsp_t imem_sb[$];
   rsp_t dmem_sb[$];
   cmd_t cmd_sb[$];

   int wt_cfg  = 0;
   int lat_cfg = 1;

   function automatic logic [31:0] slave_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_A5A5);
   endfunction

   // Drive one request in the current cycle and record what it should produce.
   task automatic req(input logic dport, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int lat, input logic [31:0] exp_rdata);
      rsp_t r;
      cmd_t c;
      r.rdata = exp_rdata;
      r.due   = (lat < 0) ? -1 : cyc + lat;
      if (addr >= Base && addr < Top) begin
         c.address = addr - Base;
         c.wr      = (wstrb != 4'h0);
         c.be      = c.wr ? wstrb : 4'hF;
         c.wdata   = wdata;
         cmd_sb.push_back(c);
      end
      if (dport == 1'b0) begin
         imem_valid = 1'b1;
         imem_addr  = addr;
         imem_sb.push_back(r);
      end else begin
         dmem_valid = 1'b1;
         dmem_addr  = addr;
         dmem_wdata = wdata;
         dmem_wstrb = wstrb;
         dmem_sb.push_back(r);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((imem_sb.size() != 0 || dmem_sb.size() != 0 || cmd_sb.size() != 0) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         fail("idle_timeout");
         imem_sb.delete();
         dmem_sb.delete();
         cmd_sb.delete();
      end
      step();
      step();
   endtask

   // Avalon slave model: stalls wt_cfg cycles, returns read data lat_cfg cycles later.
   initial begin : slave
      int stall = 0;
      int rd_cnt = 0;
      logic [31:0] rd_word = 32'h0;
      cmd_t c;
      avl_waitrequest   = 1'b0;
      avl_readdatavalid = 1'b0;
      avl_readdata      = 32'h0;
      forever begin
         @(negedge clock);
         avl_waitrequest   = 1'b0;
         avl_readdatavalid = 1'b0;
         avl_readdata      = 32'h0;
         if (!reset) begin
            stall  = 0;
            rd_cnt = 0;
         end else begin
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) begin
                  avl_readdatavalid = 1'b1;
                  avl_readdata      = rd_word;
               end
            end
            if (avl_read || avl_write) begin
               if (cmd_sb.size() == 0) begin
                  fail("unexpected_avl_command");
               end else begin
                  c = cmd_sb[0];
                  check("avl_address", avl_address, c.address);
                  check("avl_byteenable", 32'(avl_byteenable), 32'(c.be));
                  check("avl_read_write", {30'h0, avl_read, avl_write}, {30'h0, !c.wr, c.wr});
                  if (c.wr) check("avl_writedata", avl_writedata, c.wdata);
               end
               if (stall < wt_cfg) begin
                  avl_waitrequest = 1'b1;
                  stall++;
               end else begin
                  stall = 0;
                  if (cmd_sb.size() != 0) void'(cmd_sb.pop_front());
                  if (avl_read) begin
                     rd_word = slave_word(avl_address);
                     if (lat_cfg == 0) begin
                        avl_readdatavalid = 1'b1;
                        avl_readdata      = rd_word;
                     end else begin
                        rd_cnt = lat_cfg;
                     end
                  end
               end
            end
         end
      end
   end

   // Response monitor: every ready must match a scoreboard entry; rdata is 0 otherwise.
   always @(negedge clock) begin
      rsp_t r;
      if (reset === 1'b1) begin
         if (imem_ready) begin
            if (imem_sb.size() == 0) fail("imem_unexpected_ready");
            else begin
               r = imem_sb.pop_front();
               check("imem_rdata", imem_rdata, r.rdata);
               if (r.due >= 0) check("imem_ready_cycle", cyc, r.due);
            end
         end else begin
            check("imem_rdata_idle", imem_rdata, 32'h0);
         end
         if (dmem_ready) begin
            if (dmem_sb.size() == 0) fail("dmem_unexpected_ready");
            else begin
               r = dmem_sb.pop_front();
               check("dmem_rdata", dmem_rdata, r.rdata);
               if (r.due >= 0) check("dmem_ready_cycle", cyc, r.due);
            end
         end else begin
            check("dmem_rdata_idle", dmem_rdata, 32'h0);
         end
      end
   end

   // A valid must never land on an already-full holding register.
   always @(posedge clock) begin
      if (reset === 1'b1 && ((imem_valid && dut.imem_full) || (dmem_valid && dut.dmem_full)))
         fail("hold_overflow");
   end

   typedef struct {
      string       name;
      logic        dport;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          wt;
      int          lat;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 9;
   vec_t vec[NV];

   initial begin
      vec[0] = '{"imem_read",       1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 1, 3, 32'hDEADBEEF};
      vec[1] = '{"dmem_write_wait", 1'b1, 32'h8000_0100, 32'h1234_5678, 4'h3, 3, 1, 5, 32'h0};
      vec[2] = '{"dmem_read_zlat",  1'b1, 32'h8000_0200, 32'h0,         4'h0, 0, 0, 2, 32'hA5A5_A7A5};
      vec[3] = '{"imem_read_top",   1'b0, 32'h8FFF_FFFC, 32'h0,         4'h0, 2, 3, 7, 32'hAA5A_5A59};
      vec[4] = '{"dmem_oor_read",   1'b1, 32'h0000_1000, 32'h0,         4'h0, 0, 1, 2, 32'h0};
      vec[5] = '{"dmem_oor_write",  1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0, 1, 2, 32'h0};
      vec[6] = '{"imem_oor_low",    1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 1, 2, 32'h0};
      vec[7] = '{"dmem_write_fast", 1'b1, 32'h8000_0004, 32'hCAFE_BABE, 4'hF, 0, 1, 2, 32'h0};
      vec[8] = '{"dmem_read_base",  1'b1, 32'h8000_0000, 32'h0,         4'h0, 1, 1, 4, 32'hA5A5_A5A5};

      reset      = 1'b0;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      imem_addr  = 32'h0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      dmem_wstrb = 4'h0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_avl_read", 32'(avl_read), 32'h0);
      check("rst_avl_write", 32'(avl_write), 32'h0);
      check("rst_avl_address", avl_address, 32'h0);
      check("rst_avl_byteenable", 32'(avl_byteenable), 32'h0);
      check("rst_imem_ready", 32'(imem_ready), 32'h0);
      check("rst_dmem_ready", 32'(dmem_ready), 32'h0);
      check("rst_imem_rdata", imem_rdata, 32'h0);
      check("rst_dmem_rdata", dmem_rdata, 32'h0);
      reset = 1'b1;
      step();

      // Tie after reset goes to IMEM; DMEM then ties a fresh IMEM and wins.
      wt_cfg  = 0;
      lat_cfg = 1;
      req(1'b0, 32'h8000_0080, 32'h0, 4'h0, 3, slave_word(32'h80));
      req(1'b1, 32'h8000_0084, 32'h0, 4'h0, 7, slave_word(32'h84));
      step();
      step();
      step();
      step();
      req(1'b0, 32'h8000_0088, 32'h0, 4'h0, 7, slave_word(32'h88));
      step();
      wait_idle();

      // DMEM arrives while IMEM read sits in RDWAIT; command issues 2 cycles after ready.
      wt_cfg  = 0;
      lat_cfg = 5;
      req(1'b0, 32'h8000_0040, 32'h0, 4'h0, 7, slave_word(32'h40));
      step();
      step();
      step();
      req(1'b1, 32'h8000_0044, 32'hCAFE_F00D, 4'hF, 7, 32'h0);
      step();
      wait_idle();

      // Table of isolated transactions.
      for (int i = 0; i < NV; i++) begin
         wt_cfg  = vec[i].wt;
         lat_cfg = vec[i].lat;
         req(vec[i].dport, vec[i].addr, vec[i].wdata, vec[i].wstrb, vec[i].exp_lat,
             vec[i].exp_rdata);
         step();
         wait_idle();
      end

      // Reset during a stalled command, then a clean transaction.
      wt_cfg  = 10;
      lat_cfg = 1;
      req(1'b0, 32'h8000_0020, 32'h0, 4'h0, -1, 32'h0);
      step();
      step();
      check("cmd_before_reset", 32'(avl_read), 32'h1);
      reset = 1'b0;
      #1;
      check("rst_mid_avl_read", 32'(avl_read), 32'h0);
      check("rst_mid_avl_write", 32'(avl_write), 32'h0);
      check("rst_mid_imem_ready", 32'(imem_ready), 32'h0);
      check("rst_mid_dmem_ready", 32'(dmem_ready), 32'h0);
      imem_sb.delete();
      dmem_sb.delete();
      cmd_sb.delete();
      step();
      step();
      reset   = 1'b1;
      wt_cfg  = 0;
      lat_cfg = 1;
      step();
      step();
      req(1'b1, 32'h8000_0030, 32'h0, 4'h0, 3, slave_word(32'h30));
      step();
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      fail("global_timeout");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
